seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Parametrised multi-cycle barrel shifter for the ALU shift path.
- Generalises fixed-distance shift slices to any WIDTH and any shift amount.
- Supports logical left, logical right, arithmetic right and rotate left.
- Uses a valid/ready handshake and resolves SPC binary stages per clock, trading latency against combinational depth.

Parameters:
- WIDTH, 32, data width in bits; power of two, at least 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width; also the number of binary stages.
- SPC, 1, binary stages resolved per clock; range 1..SHAMT_W.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; out_valid=0, out_data=0, busy=0, in_ready=1; all internal registers cleared.
- Reset mid-operation aborts the operation and discards it; nothing is emitted.
- States and transitions:
  - IDLE: in_ready=1. On in_valid=1 at an edge, latch data/shamt/mode, set stage index k=SHAMT_W-1, go to SHIFT.
  - SHIFT: each edge applies stages k, k-1, ... k-SPC+1, stopping at stage 0. Stage j shifts by 2^j when shamt[j]=1, else passes through. Stages are applied MSB-first (16,8,4,2,1 at WIDTH=32).
  - SHIFT to DONE happens on the edge that applies stage 0.
  - DONE: out_valid=1 and out_data is stable. On out_ready=1 at an edge, go to IDLE, out_valid=0.
- Latency: out_valid rises NCYC=ceil(SHAMT_W/SPC) edges after the accepting edge. It is fixed and does not depend on shamt; shamt=0 also takes NCYC.
- Throughput: one request per NCYC+2 cycles with out_ready held high.
- in_ready is 0 in SHIFT and DONE. in_valid in those states is ignored: nothing is latched and there is no error.
- Backpressure: in DONE with out_ready=0, out_data and out_valid hold indefinitely.
- Fill rules per mode:
  - SLL: vacated low bits fill with 0.
  - SRL: vacated high bits fill with 0.
  - SRA: vacated high bits fill with the latched operand MSB. The sign is captured once at acceptance, not re-read per stage.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- Arithmetic: the shift amount is taken mod WIDTH, so the maximum shift is WIDTH-1. No flags are produced.
- The mode is latched at acceptance; changes on in_mode after acceptance have no effect.

Decomposition:
- Shared package shifter_pkg:
  - mode constants MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROL=2'b11
  - state enum IDLE/SHIFT/DONE
  - function ncyc(SHAMT_W, SPC)
- Sub-module shift_stage:
  - combinational; parameters WIDTH and DIST
  - ports: in, en, mode, sign, out
  - single fixed-distance stage covering all four modes
  - top level instantiates SHAMT_W copies (DIST=2^j) and muxes the SPC stages active for the current k.

Test Plan:
- SLL (WIDTH=32, SPC=1): data=0x0000ABCD, shamt=16 -> out_data=0xABCD0000, out_valid rises exactly 5 edges after acceptance.
- SRA vs SRL: data=0x80000000, shamt=31 -> SRA gives 0xFFFFFFFF; SRL gives 0x00000001.
- ROL and zero shift:
  - ROL data=0x80000001, shamt=1 -> 0x00000003.
  - Any mode with shamt=0, data=0x12345678 -> 0x12345678 after 5 cycles.
- Backpressure and ignore: hold out_ready=0 for 4 cycles in DONE while driving in_valid=1 with new data -> out_data holds; in_ready=0; the new request is not latched. After out_ready=1, IDLE is entered and the next request is accepted.
- Reset mid-op: pull reset_n low in SHIFT with k=2 -> out_valid=0, in_ready=1 immediately (async); no result is emitted after release.
- SPC=5: SLL data=1, shamt=31 -> 0x80000000 one edge after acceptance.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared mode codes, FSM states and latency helper for seq_shifter
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int ncyc(input int shamt_w, input int spc);
    return (shamt_w + spc - 1) / spc;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one fixed-distance shift stage covering SLL/SRL/SRA/ROL
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sign,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = in;
    case (mode)
      MODE_SLL: shifted = in << DIST;
      MODE_SRL: shifted = in >> DIST;
      MODE_SRA: shifted = {{DIST{sign}}, in[WIDTH-1:DIST]};
      MODE_ROL: shifted = {in[WIDTH-1-DIST:0], in[WIDTH-1:WIDTH-DIST]};
      default:  shifted = in;
    endcase
  end

  assign out = en ? shifted : in;

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle barrel shifter, SPC binary stages per clock, MSB stage first
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int SPC     = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam logic [SHAMT_W-1:0] K_INIT = SHAMT_W'(SHAMT_W - 1);
  localparam logic [SHAMT_W-1:0] K_STEP = SHAMT_W'(SPC);

  state_t             state;
  logic [WIDTH-1:0]   data_r;
  logic [SHAMT_W-1:0] shamt_r;
  logic [1:0]         mode_r;
  logic               sign_r;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   shift_result;

  // Slot s applies stage k-s; slots past stage 0 pass their input through.
  for (genvar s = 0; s < SPC; s++) begin : g_slot
    logic [WIDTH-1:0]   slot_in;
    logic [WIDTH-1:0]   slot_out;
    logic [WIDTH-1:0]   st_out [SHAMT_W];
    logic [SHAMT_W-1:0] idx;

    if (s == 0) begin : g_first
      assign slot_in = data_r;
    end else begin : g_next
      assign slot_in = g_slot[s-1].slot_out;
    end

    for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
      shift_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << j)
      ) u_stage (
        .in   (slot_in),
        .en   (shamt_r[j]),
        .mode (mode_r),
        .sign (sign_r),
        .out  (st_out[j])
      );
    end

    assign idx = k - SHAMT_W'(s);

    always_comb begin
      slot_out = slot_in;
      if (k >= SHAMT_W'(s)) slot_out = st_out[idx];
    end
  end

  assign shift_result = g_slot[SPC-1].slot_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      data_r    <= '0;
      shamt_r   <= '0;
      mode_r    <= MODE_SLL;
      sign_r    <= 1'b0;
      k         <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r   <= in_data;
            shamt_r  <= in_shamt;
            mode_r   <= in_mode;
            sign_r   <= in_data[WIDTH-1];
            k        <= K_INIT;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          data_r <= shift_result;
          if (k < K_STEP) begin
            out_data  <= shift_result;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k - K_STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed self-checking bench for seq_shifter (SPC=1 and SPC=5 instances)
module tb_seq_shifter;
  import shifter_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [31:0] a_in_data, a_out_data;
  logic [4:0]  a_in_shamt;
  logic [1:0]  a_in_mode;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_data, b_out_data;
  logic [4:0]  b_in_shamt;
  logic [1:0]  b_in_mode;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seq_shifter #(.WIDTH(32), .SPC(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy)
  );

  seq_shifter #(.WIDTH(32), .SPC(5)) dut5 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy)
  );

  // Run one request on instance a (sel=0) or b (sel=1); returns result and edges to out_valid.
  task automatic do_op(input bit sel, input logic [31:0] data, input logic [4:0] shamt,
                       input logic [1:0] mode, output logic [31:0] res, output int lat);
    int waited;
    res = 'x;
    lat = -1;
    waited = 0;
    @(negedge clock);
    while ((sel ? b_in_ready : a_in_ready) !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (sel) begin
      b_in_valid = 1'b1; b_in_data = data; b_in_shamt = shamt; b_in_mode = mode;
    end else begin
      a_in_valid = 1'b1; a_in_data = data; a_in_shamt = shamt; a_in_mode = mode;
    end
    @(posedge clock);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    a_in_mode  = ~mode;
    b_in_mode  = ~mode;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if ((sel ? b_out_valid : a_out_valid) === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) return;
    res = sel ? b_out_data : a_out_data;
    @(negedge clock);
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    @(posedge clock);
    #1;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=00000000", a_out_data); end
  endtask

  task automatic test_sll();
    logic [31:0] r; int lat;
    do_op(1'b0, 32'h0000ABCD, 5'd16, MODE_SLL, r, lat);
    checks++; if (r !== 32'hABCD0000) begin errors++; $display("FAIL sll_data got=%h exp=abcd0000", r); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL sll_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_sra_srl();
    logic [31:0] r; int lat;
    do_op(1'b0, 32'h80000000, 5'd31, MODE_SRA, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL sra_31 got=%h exp=ffffffff", r); end
    do_op(1'b0, 32'h80000000, 5'd31, MODE_SRL, r, lat);
    checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL srl_31 got=%h exp=00000001", r); end
    do_op(1'b0, 32'hF0F00000, 5'd6, MODE_SRA, r, lat);
    checks++; if (r !== 32'hFFC3C000) begin errors++; $display("FAIL sra_6 got=%h exp=ffc3c000", r); end
  endtask

  task automatic test_rol_zero();
    logic [31:0] r; int lat;
    do_op(1'b0, 32'h80000001, 5'd1, MODE_ROL, r, lat);
    checks++; if (r !== 32'h00000003) begin errors++; $display("FAIL rol_1 got=%h exp=00000003", r); end
    do_op(1'b0, 32'h12345678, 5'd12, MODE_ROL, r, lat);
    checks++; if (r !== 32'h45678123) begin errors++; $display("FAIL rol_12 got=%h exp=45678123", r); end
    for (int m = 0; m < 4; m++) begin
      do_op(1'b0, 32'h12345678, 5'd0, 2'(m), r, lat);
      checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL zero_shift_mode%0d got=%h exp=12345678", m, r); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL zero_shift_lat_mode%0d got=%0d exp=5", m, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; int lat; int waited;
    @(negedge clock);
    a_in_valid = 1'b1; a_in_data = 32'h00000001; a_in_shamt = 5'd4; a_in_mode = MODE_SLL;
    @(posedge clock);
    #1;
    a_in_valid = 1'b0;
    waited = 0;
    while (a_out_valid !== 1'b1 && waited < 20) begin
      @(posedge clock); #1; waited++;
    end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_done got=%b exp=1", a_out_valid); end
    @(negedge clock);
    a_in_valid = 1'b1; a_in_data = 32'hFFFFFFFF; a_in_shamt = 5'd3; a_in_mode = MODE_SRA;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      checks++; if (a_out_data !== 32'h00000010 || a_out_valid !== 1'b1)
        begin errors++; $display("FAIL bp_hold_c%0d got=%h/%b exp=00000010/1", c, a_out_data, a_out_valid); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d got=%b exp=0", c, a_in_ready); end
    end
    @(negedge clock);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b0;
    @(posedge clock); #1;
    a_out_ready = 1'b0;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0)
      begin errors++; $display("FAIL bp_release got=%b%b%b exp=100", a_in_ready, a_out_valid, a_busy); end
    do_op(1'b0, 32'h00000003, 5'd1, MODE_SLL, r, lat);
    checks++; if (r !== 32'h00000006) begin errors++; $display("FAIL bp_next_req got=%h exp=00000006", r); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clock);
    a_in_valid = 1'b1; a_in_data = 32'h0000FFFF; a_in_shamt = 5'd8; a_in_mode = MODE_SLL;
    @(posedge clock); #1;
    a_in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0)
      begin errors++; $display("FAIL midreset_async got=%b%b%b exp=010", a_out_valid, a_in_ready, a_busy); end
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (a_out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_emit got=1 exp=0"); end
  endtask

  task automatic test_spc5();
    logic [31:0] r; int lat;
    do_op(1'b1, 32'h00000001, 5'd31, MODE_SLL, r, lat);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL spc5_sll got=%h exp=80000000", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL spc5_latency got=%0d exp=1", lat); end
    do_op(1'b1, 32'h80000000, 5'd31, MODE_SRA, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL spc5_sra got=%h exp=ffffffff", r); end
    do_op(1'b1, 32'hC0000005, 5'd7, MODE_ROL, r, lat);
    checks++; if (r !== 32'h000002E0) begin errors++; $display("FAIL spc5_rol got=%h exp=000002e0", r); end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    @(negedge clock);
    a_in_valid = 1'b1; a_in_data = 32'h00000001; a_in_shamt = 5'd2; a_in_mode = MODE_SLL;
    a_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (a_in_ready === 1'b1) acc.push_back(c);
      @(negedge clock);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    checks++;
    if (acc.size() < 2) begin
      errors++; $display("FAIL b2b_accepts got=%0d exp>=2", acc.size());
    end else if (acc[1] - acc[0] !== 7) begin
      errors++; $display("FAIL b2b_period got=%0d exp=7", acc[1] - acc[0]);
    end
    repeat (10) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_mode = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_mode = '0; b_out_ready = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    test_sll();
    test_sra_srl();
    test_rol_zero();
    test_backpressure();
    test_reset_mid();
    test_spc5();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
